// File: rtl/egress_port_if.sv
// Egress port bus: crossbar-side write, downstream valid/ready and status counters.
interface egress_port_if #(
  parameter int PACKET_WIDTH = 16,
  parameter int CNT_WIDTH    = 16
);
  logic                    valid_in;
  logic [PACKET_WIDTH-1:0] data_in;
  logic                    full_out;
  logic                    valid_out;
  logic [PACKET_WIDTH-1:0] data_out;
  logic                    ready_in;
  logic                    empty_out;
  logic [CNT_WIDTH-1:0]    delivered_cnt;
  logic [CNT_WIDTH-1:0]    drop_cnt;
  logic [CNT_WIDTH-1:0]    misroute_cnt;

  // Environment side: crossbar feeding packets and downstream consumer.
  modport master (
    output valid_in, data_in, ready_in,
    input  full_out, valid_out, data_out, empty_out,
           delivered_cnt, drop_cnt, misroute_cnt
  );

  // Egress port side.
  modport slave (
    input  valid_in, data_in, ready_in,
    output full_out, valid_out, data_out, empty_out,
           delivered_cnt, drop_cnt, misroute_cnt
  );
endinterface

// File: rtl/egress_port.sv
// Egress port: target-mask check, DEPTH-entry FIFO, registered output stage
// with valid/ready handshake, and saturating delivered/drop/misroute counters.
//
// state     | meaning
// ST_EMPTY  | output register holds no packet, valid_out low
// ST_LOADED | output register holds a packet waiting for ready_in
module egress_port #(
  parameter int PORT_ID      = 0,
  parameter int PACKET_WIDTH = 16,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  egress_port_if.slave io_bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]        CNT1     = CW'(1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);

  typedef enum logic {ST_EMPTY, ST_LOADED} state_t;

  state_t                  r_state;
  logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_valid;
  logic [PACKET_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]    r_delivered;
  logic [CNT_WIDTH-1:0]    r_drop;
  logic [CNT_WIDTH-1:0]    r_misroute;

  logic          w_target_ok;
  logic          w_push;
  logic          w_drop;
  logic          w_misroute;
  logic          w_handshake;
  logic          w_fifo_ne;
  logic          w_pop;
  logic          w_loaded_nxt;
  logic [CW-1:0] w_count_nxt;

  // Misroute takes priority over full; full is the registered flag, so a
  // same-cycle pop never opens room for the incoming packet.
  assign w_target_ok  = io_bus.data_in[4+PORT_ID];
  assign w_misroute   = io_bus.valid_in & ~w_target_ok;
  assign w_drop       = io_bus.valid_in & w_target_ok & r_full;
  assign w_push       = io_bus.valid_in & w_target_ok & ~r_full;
  assign w_handshake  = (r_state == ST_LOADED) & io_bus.ready_in;
  assign w_fifo_ne    = (r_count != '0);
  assign w_pop        = w_fifo_ne & ((r_state == ST_EMPTY) | w_handshake);
  assign w_loaded_nxt = w_pop | ((r_state == ST_LOADED) & ~w_handshake);

  // Next FIFO occupancy; push and pop together cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT1;
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT1;
  end

  // FIFO storage; contents need no reset since pointers and count gate them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.data_in;
  end

  // Write pointer, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0) & ~w_loaded_nxt;
    end
  end

  // Output stage FSM: pops the FIFO head into the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_valid  <= 1'b1;
            r_state  <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (w_pop) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
          end else if (w_handshake) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_delivered <= '0;
      r_drop      <= '0;
      r_misroute  <= '0;
    end else begin
      if (w_handshake && r_delivered != '1) r_delivered <= r_delivered + STAT_ONE;
      if (w_drop && r_drop != '1)           r_drop      <= r_drop + STAT_ONE;
      if (w_misroute && r_misroute != '1)   r_misroute  <= r_misroute + STAT_ONE;
    end
  end

  assign io_bus.full_out      = r_full;
  assign io_bus.empty_out     = r_empty;
  assign io_bus.valid_out     = r_valid;
  assign io_bus.data_out      = r_data;
  assign io_bus.delivered_cnt = r_delivered;
  assign io_bus.drop_cnt      = r_drop;
  assign io_bus.misroute_cnt  = r_misroute;
endmodule

// File: tb/tb_egress_port.sv
// Bench for egress_port (PORT_ID=2): directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_egress_port;
  localparam int PORT_ID = 2;
  localparam int PW      = 16;
  localparam int DEPTH   = 8;
  localparam int CW      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  egress_port_if #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  egress_port #(.PORT_ID(PORT_ID), .PACKET_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: packets waiting in the FIFO and the one on the output.
  logic [PW-1:0] fifo_q[$];
  logic [PW-1:0] out_q[$];
  logic [PW-1:0] m_data;
  logic [CW-1:0] m_del, m_drop, m_mis;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] pkt(input logic [3:0] mask, input logic [5:0] pl);
    return {pl, 2'b01, mask, 4'h3};
  endfunction

  task automatic model_edge(input logic vin, input logic [PW-1:0] din,
                            input logic rdy, input logic rst);
    bit hs, pop, acc;
    if (!rst) begin
      fifo_q.delete();
      out_q.delete();
      m_data = '0;
      m_del = '0; m_drop = '0; m_mis = '0;
      return;
    end
    hs  = (out_q.size() != 0) && rdy;
    pop = (fifo_q.size() != 0) && ((out_q.size() == 0) || hs);
    acc = 1'b0;
    if (vin) begin
      if (!din[4+PORT_ID])             m_mis  = sat_inc(m_mis);
      else if (fifo_q.size() == DEPTH) m_drop = sat_inc(m_drop);
      else                             acc = 1'b1;
    end
    if (hs) begin
      void'(out_q.pop_front());
      m_del = sat_inc(m_del);
    end
    if (pop) begin
      out_q.push_back(fifo_q.pop_front());
      m_data = out_q[0];
    end
    if (acc) fifo_q.push_back(din);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid_out", 32'(bus.valid_out), 32'(out_q.size() != 0));
    check("data_out", 32'(bus.data_out), 32'(m_data));
    check("full_out", 32'(bus.full_out), 32'(fifo_q.size() == DEPTH));
    check("empty_out", 32'(bus.empty_out), 32'(fifo_q.size() == 0 && out_q.size() == 0));
    check("delivered_cnt", 32'(bus.delivered_cnt), 32'(m_del));
    check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    check("misroute_cnt", 32'(bus.misroute_cnt), 32'(m_mis));
  endtask

  // One clock: drive away from the edge, advance the model, sample after it.
  task automatic step(input logic vin, input logic [PW-1:0] din,
                      input logic rdy, input logic rst = 1'b1);
    @(negedge clk);
    bus.valid_in = vin;
    bus.data_in  = din;
    bus.ready_in = rdy;
    rst_n        = rst;
    @(posedge clk);
    model_edge(vin, din, rdy, rst);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;

    // Reset state.
    do_reset();
    check("rst_empty", 32'(bus.empty_out), 32'd1);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);

    // Single packet end to end.
    step(1'b1, 16'h2543, 1'b1);
    check("single_lat1", 32'(bus.valid_out), 32'd0);
    step(1'b0, '0, 1'b1);
    check("single_valid", 32'(bus.valid_out), 32'd1);
    check("single_data", 32'(bus.data_out), 32'h2543);
    step(1'b0, '0, 1'b1);
    check("single_delivered", 32'(bus.delivered_cnt), 32'd1);
    check("single_empty", 32'(bus.empty_out), 32'd1);

    // Misroute.
    do_reset();
    step(1'b1, 16'h0031, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("misroute_valid", 32'(bus.valid_out), 32'd0);
    check("misroute_cnt1", 32'(bus.misroute_cnt), 32'd1);
    check("misroute_drop0", 32'(bus.drop_cnt), 32'd0);

    // Backpressure and overflow, then full drain.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, pkt(4'b0100, 6'(i)), 1'b0);
    check("ovf_full", 32'(bus.full_out), 32'd1);
    check("ovf_drop", 32'(bus.drop_cnt), 32'd3);
    for (int i = 0; i < 9; i++) begin
      check("drain_order", 32'(bus.data_out), 32'(pkt(4'b0100, 6'(i))));
      step(1'b0, '0, 1'b1);
    end
    check("drain_delivered", 32'(bus.delivered_cnt), 32'd9);
    check("drain_empty", 32'(bus.empty_out), 32'd1);

    // Full with a pop in the same cycle: the write is still rejected.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, pkt(4'b1100, 6'(i)), 1'b0);
    check("fullpop_pre", 32'(bus.full_out), 32'd1);
    step(1'b1, pkt(4'b0100, 6'h3f), 1'b1);
    check("fullpop_drop", 32'(bus.drop_cnt), 32'd1);
    check("fullpop_notfull", 32'(bus.full_out), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Pointer wrap: 20 packets, ready toggling each cycle.
    do_reset();
    for (int i = 0; i < 40; i++)
      step(1'(i % 2 == 0), pkt(4'b0100, 6'(i / 2)), 1'(i % 2));
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'(i % 2));
    check("wrap_delivered", 32'(bus.delivered_cnt), 32'd20);
    check("wrap_drop", 32'(bus.drop_cnt), 32'd0);

    // Reset mid-operation with packets buffered and one on the output.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, pkt(4'b0110, 6'(i + 10)), 1'b0);
    step(1'b0, '0, 1'b0);
    check("mid_valid_pre", 32'(bus.valid_out), 32'd1);
    step(1'b1, pkt(4'b0100, 6'h2a), 1'b0, 1'b0);
    check("mid_valid", 32'(bus.valid_out), 32'd0);
    check("mid_empty", 32'(bus.empty_out), 32'd1);
    check("mid_delivered", 32'(bus.delivered_cnt), 32'd0);
    step(1'b1, pkt(4'b0100, 6'h15), 1'b1);
    step(1'b0, '0, 1'b1);
    check("mid_after", 32'(bus.data_out), 32'(pkt(4'b0100, 6'h15)));
    step(1'b0, '0, 1'b1);
    check("mid_after_cnt", 32'(bus.delivered_cnt), 32'd1);

    // Random traffic with random masks and backpressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [PW-1:0] d;
      d = PW'($urandom);
      if ($urandom_range(0, 3) != 0) d[4+PORT_ID] = 1'b1;
      step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    check("rand_empty", 32'(bus.empty_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/egress_port.md
# egress_port

Output side of one `switch_4port` port: takes packets leaving the crossbar for this port, buffers them, and presents them downstream on a registered valid/ready handshake. It is the transmit counterpart of the ingress `switch_port`/`fifo` path. It enforces routing sanity by discarding packets whose target mask excludes this port, and it exposes delivered, dropped and misrouted counters for the scoreboard integrity report.

## Interface
Parameters:
- `PORT_ID`, 0: index of this port (0-3); selects the target-mask bit to check.
- `PACKET_WIDTH`, 16: packet width. Fields are `[3:0]` source, `[7:4]` one-hot target mask, `[9:8]` type, and the remaining bits are payload.
- `DEPTH`, 8: FIFO entries (power of 2).
- `CNT_WIDTH`, 16: width of each counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  crossbar presents a packet this cycle.
- `data_in`  in  PACKET_WIDTH  packet from crossbar.
- `full_out`  out  1  FIFO full; the arbiter must not grant this port.
- `valid_out`  out  1  packet available downstream.
- `data_out`  out  PACKET_WIDTH  packet to downstream.
- `ready_in`  in  1  downstream accepts when high with `valid_out`.
- `empty_out`  out  1  FIFO and output stage both empty.
- `delivered_cnt`  out  CNT_WIDTH  packets handed off downstream.
- `drop_cnt`  out  CNT_WIDTH  packets rejected because the FIFO was full.
- `misroute_cnt`  out  CNT_WIDTH  packets discarded for a bad target mask.

## Operation
Input:
- A packet is sampled when `valid_in` is high.
- Misroute: if `data_in[4+PORT_ID]`==0, the packet is discarded and `misroute_cnt` increments. The misroute check takes priority over the full check.
- Otherwise, if `full_out`==1 the packet is dropped and `drop_cnt` increments.
- Otherwise the packet is written to the FIFO.
- `full_out` is derived from the count register at the start of the cycle. A write is rejected while full even if the FIFO pops in the same cycle.

FIFO:
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Count range is 0..DEPTH. A simultaneous push and pop leaves the count unchanged.

Output stage FSM:
- EMPTY: `valid_out`=0. If the FIFO is non-empty, pop the head into `data_out` and go to LOADED.
- LOADED: `valid_out`=1, and `data_out` is held stable.
  - On `ready_in`=1, `delivered_cnt` increments.
  - If the FIFO is non-empty, load the next head in the same edge and stay in LOADED (back-to-back, one packet per cycle).
  - Otherwise go to EMPTY.
- On `ready_in`=0, hold. `valid_out` never drops without a handshake.

Capacity and flags:
- Total capacity is DEPTH+1 (FIFO plus output register).
- `empty_out` = (count==0) && state==EMPTY.

Counters:
- All counters saturate at all-ones; no wrap-around.

## Timing
- All outputs are registered. Reset values: `valid_out` 0, `data_out` 0, `full_out` 0, `empty_out` 1, all counters 0, state EMPTY, pointers 0.
- Reset is taken at an edge where `rst_n`=0 and discards all buffered packets, including a packet held mid-handshake. Outputs reach reset values after that edge, and `valid_in` in that cycle is ignored.
- Latency with an empty block: packet sampled at edge N (FIFO write) → loaded at edge N+1 → `valid_out`=1 in the cycle after N+1.
- `full_out` rises in the cycle after the DEPTH-th accepted write and falls in the cycle after the first pop from full.
- Counter updates are visible one cycle after the causing event.

## Test plan
- Single packet, PORT_ID=2, `data_in`=16'h2543 (target 0100), `ready_in`=1 → `valid_out` two cycles later with `data_out`=16'h2543; `delivered_cnt`=1; `empty_out` returns to 1.
- Misroute: PORT_ID=2, `data_in`=16'h0031 (target 0011) → no `valid_out`; `misroute_cnt`=1; `drop_cnt`=0.
- Backpressure/overflow: `ready_in`=0, send 12 valid packets on consecutive cycles.
  - 9 are stored (1 in the output register, 8 in the FIFO), `full_out`=1, `drop_cnt`=3.
  - Then raise `ready_in`: 9 packets are delivered in order on 9 consecutive cycles; `delivered_cnt`=9.
- Full with simultaneous pop: FIFO at 8 and a handshake occurs in the same cycle as `valid_in` → the packet is dropped and `drop_cnt` increments; the next cycle `full_out`=0.
- Pointer wrap-around: stream 20 packets with `ready_in` toggling 1/0 each cycle → all 20 delivered with payloads in order, data stable while stalled, `drop_cnt`=0.
- Reset mid-operation: with 5 packets buffered and `valid_out`=1, pulse `rst_n`=0 for one cycle → next cycle `valid_out`=0, `empty_out`=1, all counters 0. A new packet afterwards is delivered normally.
